// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232_send arbiter: FSM encoding and header format.
package rs232_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      BODY   = 2'd2
   } state_t;

   // Upper nibble of every source-ID header byte.
   localparam logic [3:0] HDR_NIBBLE = 4'hA;

   // Header byte announcing which requester owns the packet that follows.
   function automatic logic [7:0] header_byte(input logic [3:0] id);
      return {HDR_NIBBLE, id};
   endfunction

endpackage

// File: rtl/rs232_rr_select.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping at N-1 back to 0.
module rs232_rr_select
   import rs232_pkg::*;
#(
   parameter int N  = 4,
   parameter int GW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] ptr,
   output logic [GW-1:0] gnt,
   output logic          any
);

   logic [N-1:0] rot;
   int           off;
   int           sum;

   // Rotate requests so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
   always_comb begin
      rot = N'({req, req} >> ptr);
      off = 0;
      any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = k;
            any = 1'b1;
         end
      end
      sum = int'(ptr) + off;
      if (sum > N - 1) begin
         sum = sum - N;
      end
      gnt = GW'(sum);
   end

endmodule

// File: rtl/rs232_send_arbiter.sv
// Packet-atomic round-robin arbiter sharing one rs232_send byte port between
// N requesters, with optional source-ID header and mid-packet stall release.
module rs232_send_arbiter
   import rs232_pkg::*;
#(
   parameter int N         = 4,
   parameter int HEADER_EN = 1,
   parameter int TIMEOUT   = 0
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic [8*N-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   input  logic [N-1:0]   in_last,
   output logic [N-1:0]   in_ready,
   output logic [7:0]     out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           busy
);

   localparam int GW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [GW-1:0] LAST_IDX = GW'(N - 1);
   localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   state_t        state, state_nx;
   logic [GW-1:0] grant, grant_nx;
   logic [GW-1:0] ptr, ptr_nx;
   logic [GW-1:0] pick;
   logic          pick_any;
   logic [CW-1:0] cnt, cnt_nx;
   logic [7:0]    sel_data;
   logic          sel_valid;
   logic          sel_last;

   // Successor index with explicit wrap so non-power-of-two N works.
   function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   rs232_rr_select #(
      .N  (N),
      .GW (GW)
   ) u_rr_select (
      .req (in_valid),
      .ptr (ptr),
      .gnt (pick),
      .any (pick_any)
   );

   // Route the granted requester's byte, valid and last flag.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (grant == GW'(i)) begin
            sel_data  = in_data[8*i +: 8];
            sel_valid = in_valid[i];
            sel_last  = in_last[i];
         end
      end
   end

   // State, grant, round-robin pointer and stall counter registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         ptr   <= ptr_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state logic and output muxing; a last-byte handshake takes priority over stall release.
   always_comb begin
      state_nx  = state;
      grant_nx  = grant;
      ptr_nx    = ptr;
      cnt_nx    = cnt;
      out_data  = '0;
      out_valid = 1'b0;
      in_ready  = '0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (pick_any) begin
               grant_nx = pick;
               state_nx = (HEADER_EN != 0) ? HEADER : BODY;
            end
         end
         HEADER: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = header_byte(4'(grant));
            cnt_nx    = '0;
            if (out_ready) begin
               state_nx = BODY;
            end
         end
         BODY: begin
            busy      = 1'b1;
            out_data  = sel_data;
            out_valid = sel_valid;
            for (int i = 0; i < N; i++) begin
               if (grant == GW'(i)) begin
                  in_ready[i] = out_ready;
               end
            end
            if (sel_valid && out_ready) begin
               cnt_nx = '0;
               if (sel_last) begin
                  state_nx = IDLE;
                  ptr_nx   = wrap_inc(grant);
               end
            end else if (!sel_valid && (TIMEOUT > 0)) begin
               if (cnt == CNT_MAX) begin
                  state_nx = IDLE;
                  ptr_nx   = wrap_inc(grant);
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule
